// File: rtl/enc_pkg.sv
// Shared types and the decode function for the binary-to-vector encoder.
// The decode function works on a fixed maximum width; callers slice the low N_OUT bits.
package enc_pkg;

    typedef enum logic [1:0] {
        ENC_ONEHOT   = 2'b00,
        ENC_THERM    = 2'b01,
        ENC_ONEHOT_N = 2'b10,
        ENC_RSVD     = 2'b11
    } enc_mode_e;

    localparam int ENC_MAX_OUT  = 256;
    localparam int ENC_MAX_IN_W = 32;

    // Returns {err, vector}. Bits at and above n_out are always zero.
    function automatic logic [ENC_MAX_OUT:0] enc_decode(
        input logic [31:0] code,
        input logic [31:0] n_out,
        input enc_mode_e   mode
    );
        logic [ENC_MAX_OUT-1:0] vec;
        logic                   err;
        vec = '0;
        err = (code >= n_out) || (mode == ENC_RSVD);
        // Out-of-range codes fall out naturally: no index matches, every index is <= code.
        for (int i = 0; i < ENC_MAX_OUT; i++) begin
            if (32'(i) < n_out) begin
                case (mode)
                    ENC_ONEHOT:   vec[i] = (code == 32'(i));
                    ENC_THERM:    vec[i] = (32'(i) <= code);
                    ENC_ONEHOT_N: vec[i] = (code != 32'(i));
                    default:      vec[i] = 1'b0;
                endcase
            end
        end
        return {err, vec};
    endfunction

endpackage

// File: rtl/enc_skid_buf.sv
// Two-entry valid/ready skid buffer: an output register plus one skid register.
// up_ready is a flop that tracks "skid empty", so it never depends on dn_ready.
module enc_skid_buf
    import enc_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         up_valid,
    output logic         up_ready,
    input  logic [W-1:0] up_data,
    output logic         dn_valid,
    input  logic         dn_ready,
    output logic [W-1:0] dn_data
);

    logic         skid_valid;
    logic [W-1:0] skid_data;
    logic         accept;

    assign accept = up_valid && up_ready;

    // NOTE: non-blocking assignments keep every register update tied to the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: data registers are reset too, so a cleared block presents out=0.
            dn_valid   <= 1'b0;
            dn_data    <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            up_ready   <= 1'b1;
        end else if (skid_valid) begin
            // Skid full implies output full and up_ready low: only draining is possible.
            if (dn_ready) begin
                dn_data    <= skid_data;
                skid_valid <= 1'b0;
                up_ready   <= 1'b1;
            end
        end else if (accept) begin
            if (!dn_valid || dn_ready) begin
                dn_data  <= up_data;
                dn_valid <= 1'b1;
            end else begin
                skid_data  <= up_data;
                skid_valid <= 1'b1;
                up_ready   <= 1'b0;
            end
        end else if (dn_ready) begin
            dn_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/enc_bin2onehot_pipe.sv
// Pipelined binary decoder (one-hot / thermometer / inverted one-hot) with skid
// buffering and a saturating out-of-range counter. Supports IN_W <= 32, N_OUT <= 256.
module enc_bin2onehot_pipe
    import enc_pkg::*;
#(
    parameter int IN_W  = 4,
    parameter int N_OUT = 15,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_OUT-1:0] out,
    output logic             out_err,
    output logic [CNT_W-1:0] oor_cnt,
    input  logic             cnt_clr
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [ENC_MAX_OUT:0] dec_full;
    logic [N_OUT:0]       payload;
    logic [N_OUT:0]       dn_payload;
    logic                 accept;
    logic                 oor;

    assign dec_full = enc_decode(32'(in), 32'(N_OUT), enc_mode_e'(mode));
    assign payload  = {dec_full[ENC_MAX_OUT], dec_full[N_OUT-1:0]};

    generate
        if (N_OUT < ENC_MAX_OUT) begin : g_unused
            logic unused_dec;
            assign unused_dec = ^dec_full[ENC_MAX_OUT-1:N_OUT];
        end
    endgenerate

    assign accept = in_valid && in_ready;
    // Full-width compare: with IN_W=4, N_OUT=15 the code 15 is out of range.
    assign oor    = 32'(in) >= 32'(N_OUT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            oor_cnt <= '0;
        end else if (cnt_clr) begin
            oor_cnt <= '0;
        end else if (accept && oor && (oor_cnt != CNT_MAX)) begin
            oor_cnt <= oor_cnt + CNT_W'(1);
        end
    end

    enc_skid_buf #(
        .W (N_OUT + 1)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .up_valid (in_valid),
        .up_ready (in_ready),
        .up_data  (payload),
        .dn_valid (out_valid),
        .dn_ready (out_ready),
        .dn_data  (dn_payload)
    );

    assign out     = dn_payload[N_OUT-1:0];
    assign out_err = dn_payload[N_OUT];

endmodule

// File: tb/tb_enc_bin2onehot_pipe.sv
// Directed and randomised checks for enc_bin2onehot_pipe at IN_W=4, N_OUT=15, CNT_W=8.
module tb_enc_bin2onehot_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  code;
    logic [1:0]  mode;
    logic        out_valid;
    logic        out_ready;
    logic [14:0] dout;
    logic        out_err;
    logic [7:0]  oor_cnt;
    logic        cnt_clr;

    int tests = 0;
    int fails = 0;

    enc_bin2onehot_pipe #(
        .IN_W  (4),
        .N_OUT (15),
        .CNT_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (code),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (dout),
        .out_err   (out_err),
        .oor_cnt   (oor_cnt),
        .cnt_clr   (cnt_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Independent reference: {err, vector} for N_OUT=15.
    function automatic logic [15:0] ref_dec(input logic [3:0] c, input logic [1:0] m);
        logic [14:0] v;
        logic [15:0] t;
        logic        oor;
        oor = (int'(c) >= 15);
        t   = (16'd2 << c) - 16'd1;
        case (m)
            2'b00:   v = oor ? 15'h0000 : (15'd1 << c);
            2'b01:   v = oor ? 15'h7FFF : t[14:0];
            2'b10:   v = oor ? 15'h7FFF : ~(15'd1 << c);
            default: v = 15'h0000;
        endcase
        return {oor || (m == 2'b11), v};
    endfunction

    typedef struct {
        logic [3:0]  code;
        logic [1:0]  mode;
        logic [14:0] exp_out;
        logic        exp_err;
    } vec_t;

    vec_t        vecs[12];
    logic [14:0] rec[$];
    logic [15:0] exp_q[$];
    logic        exp_rdy[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          exp_cnt;
        int          stalls;
        int          idx;
        int          sent;
        int          got;
        int          cyc;
        logic        acc;
        logic        fire;
        logic        hold;
        logic [15:0] e;

        vecs[0]  = '{4'd5,  2'b00, 15'h0020, 1'b0};
        vecs[1]  = '{4'd3,  2'b01, 15'h000F, 1'b0};
        vecs[2]  = '{4'd0,  2'b10, 15'h7FFE, 1'b0};
        vecs[3]  = '{4'd15, 2'b00, 15'h0000, 1'b1};
        vecs[4]  = '{4'd15, 2'b01, 15'h7FFF, 1'b1};
        vecs[5]  = '{4'd15, 2'b10, 15'h7FFF, 1'b1};
        vecs[6]  = '{4'd14, 2'b00, 15'h4000, 1'b0};
        vecs[7]  = '{4'd14, 2'b01, 15'h7FFF, 1'b0};
        vecs[8]  = '{4'd0,  2'b01, 15'h0001, 1'b0};
        vecs[9]  = '{4'd2,  2'b11, 15'h0000, 1'b1};
        vecs[10] = '{4'd15, 2'b11, 15'h0000, 1'b1};
        vecs[11] = '{4'd7,  2'b10, 15'h7F7F, 1'b0};
        exp_rdy  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        rst = 1'b0; in_valid = 1'b0; code = '0; mode = '0; out_ready = 1'b1; cnt_clr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out", 32'(dout), 32'd0);
        check("reset_out_err", 32'(out_err), 32'd0);
        check("reset_oor_cnt", 32'(oor_cnt), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);

        // Table: one beat per cycle, checked one cycle after acceptance.
        exp_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            in_valid = 1'b1; code = vecs[i].code; mode = vecs[i].mode;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (vecs[i].code == 4'd15) exp_cnt++;
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("vec%0d_out", i), 32'(dout), 32'(vecs[i].exp_out));
            check($sformatf("vec%0d_err", i), 32'(out_err), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_cnt", i), 32'(oor_cnt), 32'(exp_cnt));
        end

        // Counter clear, then saturation with a continuous out-of-range stream.
        @(negedge clk);
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        check("cnt_clear", 32'(oor_cnt), 32'd0);
        stalls = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            in_valid = 1'b1; code = 4'd15; mode = 2'b00;
            if (!in_ready) stalls++;
            @(posedge clk);
            #1;
            if (i == 0) check("cnt_first", 32'(oor_cnt), 32'd1);
        end
        in_valid = 1'b0;
        check("cnt_saturate", 32'(oor_cnt), 32'd255);
        check("full_rate_stalls", 32'(stalls), 32'd0);
        @(negedge clk);
        in_valid = 1'b1; code = 4'd15; mode = 2'b00; cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; cnt_clr = 1'b0;
        check("clr_wins", 32'(oor_cnt), 32'd0);
        check("clr_beat_err", 32'(out_err), 32'd1);
        check("clr_beat_out", 32'(dout), 32'd0);
        repeat (2) @(negedge clk);

        // Back-pressure: stream 0..3, out_ready low for cycles 2..4.
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            out_ready = !(c >= 2 && c <= 4);
            if (idx < 4) begin
                in_valid = 1'b1; code = 4'(idx); mode = 2'b00;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            check($sformatf("bp_in_ready_c%0d", c), 32'(in_ready), 32'(exp_rdy[c]));
            if (c >= 3 && c <= 5) begin
                check($sformatf("bp_stable_out_c%0d", c), 32'(dout), 32'h0002);
                check($sformatf("bp_stable_valid_c%0d", c), 32'(out_valid), 32'd1);
            end
            acc  = in_valid && in_ready;
            fire = out_valid && out_ready;
            if (fire) rec.push_back(dout);
            @(posedge clk);
            if (acc) idx++;
        end
        in_valid = 1'b0;
        check("bp_count", 32'(rec.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < rec.size()) check($sformatf("bp_order%0d", k), 32'(rec[k]), 32'(1) << k);
        end

        // Reset with both registers full discards everything at once.
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; code = 4'd1; mode = 2'b00;
        @(negedge clk);
        code = 4'd2;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("full_in_ready", 32'(in_ready), 32'd0);
        #2;
        rst = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out", 32'(dout), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; code = 4'd6; mode = 2'b00;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("post_rst_valid", 32'(out_valid), 32'd1);
        check("post_rst_out", 32'(dout), 32'h0040);
        check("post_rst_cnt", 32'(oor_cnt), 32'd0);

        // Random valid/ready at 50% on both sides against the reference model.
        @(negedge clk);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        exp_cnt = 0; sent = 0; got = 0; cyc = 0; hold = 1'b0;
        while (got < 10000 && cyc < 80000) begin
            @(negedge clk);
            if (!hold) begin
                if (sent < 10000 && $urandom_range(1, 0) == 1) begin
                    in_valid = 1'b1; code = 4'($urandom); mode = 2'($urandom);
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(1, 0) == 1);
            #1;
            acc  = in_valid && in_ready;
            fire = out_valid && out_ready;
            if (acc) begin
                exp_q.push_back(ref_dec(code, mode));
                sent++;
                if (code == 4'd15 && exp_cnt != 255) exp_cnt++;
            end
            if (fire) begin
                if (exp_q.size() == 0) begin
                    check("rand_spurious_beat", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("rand_beat%0d", got), 32'({out_err, dout}), 32'(e));
                end
                got++;
            end
            hold = in_valid && !acc;
            @(posedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        check("rand_beats_done", 32'(got), 32'd10000);
        @(negedge clk);
        check("rand_oor_cnt", 32'(oor_cnt), 32'(exp_cnt));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
